// File: rtl/dnc_matrix_vector_stream_if.sv
// dnc_matrix_vector_stream_if: start/ready control, X/W/B input streams and Y result stream
interface dnc_matrix_vector_stream_if #(
    parameter int DATA_SIZE = 32,
    parameter int CONTROL_SIZE = 16
);
    logic start;
    logic ready;
    logic [CONTROL_SIZE-1:0] size_i;
    logic [CONTROL_SIZE-1:0] size_j;
    logic x_en;
    logic signed [DATA_SIZE-1:0] x_data;
    logic x_ack;
    logic w_en;
    logic signed [DATA_SIZE-1:0] w_data;
    logic w_ack_j;
    logic w_ack_i;
    logic b_en;
    logic signed [DATA_SIZE-1:0] b_data;
    logic b_ack;
    logic y_en;
    logic signed [DATA_SIZE-1:0] y_data;
    logic overflow;
    modport master (
        output start, size_i, size_j, x_en, x_data, w_en, w_data, b_en, b_data,
        input ready, x_ack, w_ack_j, w_ack_i, b_ack, y_en, y_data, overflow
    );
    modport slave (
        input start, size_i, size_j, x_en, x_data, w_en, w_data, b_en, b_data,
        output ready, x_ack, w_ack_j, w_ack_i, b_ack, y_en, y_data, overflow
    );
endinterface

// File: rtl/dnc_matrix_vector_stream.sv
// dnc_matrix_vector_stream: streaming Y[i] = B[i] + sum_j W[i][j]*X[j]; define DNC_MATRIX_VECTOR_STREAM_SATURATION_EN for saturating arithmetic
module dnc_matrix_vector_stream #(
    parameter int DATA_SIZE = 32,
    parameter int CONTROL_SIZE = 16,
    parameter int MAX_J = 64
) (
    input logic clk,
    input logic rst,
    dnc_matrix_vector_stream_if.slave bus
);
    localparam int JW = MAX_J > 1 ? $clog2(MAX_J) : 1;
    localparam logic [CONTROL_SIZE-1:0] J_MAX = CONTROL_SIZE'(MAX_J);
    localparam logic [CONTROL_SIZE-1:0] ONE = CONTROL_SIZE'(1);
    typedef enum logic [2:0] {IDLE, LOAD_X, ROW_BIAS, ROW_MAC, ROW_OUT, DONE} state_t;
    state_t state;
    logic [CONTROL_SIZE-1:0] n_i;
    logic [CONTROL_SIZE-1:0] n_j;
    logic [CONTROL_SIZE-1:0] i;
    logic [CONTROL_SIZE-1:0] j;
    logic [CONTROL_SIZE-1:0] j_clamp;
    logic last_j;
    logic signed [DATA_SIZE-1:0] acc;
    logic signed [DATA_SIZE-1:0] xbuf [MAX_J];
    logic signed [DATA_SIZE-1:0] xr;
    logic signed [DATA_SIZE-1:0] sum;
    logic mac_ovf;
    logic ovf;
    assign j_clamp = bus.size_j > J_MAX ? J_MAX : bus.size_j;
    assign last_j = j == n_j - ONE;
    assign xr = xbuf[j[JW-1:0]];
    assign bus.overflow = ovf;
`ifdef DNC_MATRIX_VECTOR_STREAM_SATURATION_EN
    localparam logic signed [DATA_SIZE-1:0] S_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [DATA_SIZE-1:0] S_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
    logic [2*DATA_SIZE-1:0] prod;
    logic signed [DATA_SIZE-1:0] term;
    logic [DATA_SIZE:0] wide;
    logic p_ovf;
    logic s_ovf;
    // saturate the full product first, then saturate the accumulation
    always_comb begin
        prod = {{DATA_SIZE{bus.w_data[DATA_SIZE-1]}}, bus.w_data} * {{DATA_SIZE{xr[DATA_SIZE-1]}}, xr};
        p_ovf = |prod[2*DATA_SIZE-1:DATA_SIZE-1] && !(&prod[2*DATA_SIZE-1:DATA_SIZE-1]);
        term = p_ovf ? (prod[2*DATA_SIZE-1] ? S_MIN : S_MAX) : prod[DATA_SIZE-1:0];
        wide = {acc[DATA_SIZE-1], acc} + {term[DATA_SIZE-1], term};
        s_ovf = wide[DATA_SIZE] != wide[DATA_SIZE-1];
        sum = s_ovf ? (wide[DATA_SIZE] ? S_MIN : S_MAX) : wide[DATA_SIZE-1:0];
        mac_ovf = p_ovf | s_ovf;
    end
`else
    // wrap-around multiply-accumulate: low DATA_SIZE bits of product and sum
    always_comb begin
        sum = acc + bus.w_data * xr;
        mac_ovf = 1'b0;
    end
`endif
    // X buffer: written only while loading, contents need no reset
    always_ff @(posedge clk)
        if (state == LOAD_X && bus.x_en) xbuf[j[JW-1:0]] <= bus.x_data;
    // control FSM with registered handshake pulses, result and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            n_i <= '0;
            n_j <= '0;
            i <= '0;
            j <= '0;
            acc <= '0;
            ovf <= 1'b0;
            bus.ready <= 1'b0;
            bus.x_ack <= 1'b0;
            bus.w_ack_j <= 1'b0;
            bus.w_ack_i <= 1'b0;
            bus.b_ack <= 1'b0;
            bus.y_en <= 1'b0;
            bus.y_data <= '0;
        end else begin
            bus.ready <= 1'b0;
            bus.x_ack <= 1'b0;
            bus.w_ack_j <= 1'b0;
            bus.w_ack_i <= 1'b0;
            bus.b_ack <= 1'b0;
            bus.y_en <= 1'b0;
            case (state)
                IDLE: if (bus.start && !bus.ready) begin
                    n_i <= bus.size_i;
                    n_j <= j_clamp;
                    i <= '0;
                    j <= '0;
                    ovf <= 1'b0;
                    state <= bus.size_i == '0 ? DONE : (j_clamp == '0 ? ROW_BIAS : LOAD_X);
                end
                LOAD_X: if (bus.x_en) begin
                    bus.x_ack <= 1'b1;
                    j <= last_j ? '0 : j + ONE;
                    if (last_j) state <= ROW_BIAS;
                end
                ROW_BIAS: if (bus.b_en) begin
                    acc <= bus.b_data;
                    bus.b_ack <= 1'b1;
                    state <= n_j == '0 ? ROW_OUT : ROW_MAC;
                end
                ROW_MAC: if (bus.w_en) begin
                    acc <= sum;
                    ovf <= ovf | mac_ovf;
                    bus.w_ack_j <= 1'b1;
                    bus.w_ack_i <= last_j;
                    j <= last_j ? '0 : j + ONE;
                    if (last_j) state <= ROW_OUT;
                end
                ROW_OUT: begin
                    bus.y_data <= acc;
                    bus.y_en <= 1'b1;
                    i <= i + ONE;
                    j <= '0;
                    state <= i + ONE < n_i ? ROW_BIAS : DONE;
                end
                DONE: begin
                    bus.ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
